// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port (IF) and a load/store port (LS) onto one single-port
// memory with 1-cycle read latency. LS has priority unless IF has starved.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  err_bits
);

    localparam int CNT_W = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_nxt;
    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic             r_resp_zero;
    logic             w_resp_zero_nxt;
    logic [1:0]       r_err;
    logic [1:0]       w_err_nxt;
    logic             w_force_if;
    logic             w_if_mis;
    logic             w_ls_mis;
    logic             w_if_gnt;
    logic             w_ls_gnt;

    always_comb begin
        w_force_if = (r_starve_cnt == LIMIT_C);
        w_if_mis   = |if_addr[1:0];
        w_ls_mis   = |ls_addr[1:0];
        w_ls_gnt   = !rst && ls_req && !(if_req && w_force_if);
        w_if_gnt   = !rst && if_req && !w_ls_gnt;
    end

    assign if_gnt = w_if_gnt;
    assign ls_gnt = w_ls_gnt;

    // Misaligned grants are acknowledged but never reach the memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_ls_gnt && !w_ls_mis) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (w_if_gnt && !w_if_mis) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    always_comb begin
        w_starve_nxt    = r_starve_cnt;
        w_owner_nxt     = OWN_NONE;
        w_resp_zero_nxt = 1'b0;
        w_err_nxt       = r_err;
        if (w_if_gnt) begin
            w_starve_nxt = '0;
        end else if (if_req && (r_starve_cnt != LIMIT_C)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
        if (w_if_gnt) begin
            w_owner_nxt     = OWN_IF;
            w_resp_zero_nxt = w_if_mis;
            w_err_nxt[0]    = r_err[0] | w_if_mis;
        end else if (w_ls_gnt) begin
            // An aligned store completes on the grant and owns no response.
            if (w_ls_mis || !ls_we) begin
                w_owner_nxt = OWN_LS;
            end
            w_resp_zero_nxt = w_ls_mis;
            w_err_nxt[1]    = r_err[1] | w_ls_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_owner      <= OWN_NONE;
            r_resp_zero  <= 1'b0;
            r_err        <= 2'b00;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_owner      <= w_owner_nxt;
            r_resp_zero  <= w_resp_zero_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        if_rvalid = !rst && (r_owner == OWN_IF);
        ls_rvalid = !rst && (r_owner == OWN_LS);
        if_rdata  = (if_rvalid && !r_resp_zero) ? mem_rdata : '0;
        ls_rdata  = (ls_rvalid && !r_resp_zero) ? mem_rdata : '0;
    end

    assign err_bits = r_err;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive IF denials before IF is forced priority.
REQ-002 SHALL have ports clk  in  1  core clock, rising-edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have if_req  in  1 and if_addr  in  32  fetch request and byte address.
REQ-005 SHALL have if_gnt  out  1, if_rvalid  out  1 and if_rdata  out  32  fetch grant, read-data valid and read data.
REQ-006 SHALL have ls_req  in  1, ls_we  in  1, ls_addr  in  32 and ls_wdata  in  32  load/store request, write enable, address and write data.
REQ-007 SHALL have ls_gnt  out  1, ls_rvalid  out  1 and ls_rdata  out  32  load/store grant, load-data valid and load data.
REQ-008 SHALL have mem_en  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32 and mem_rdata  in  32  single-port unified memory.
REQ-009 SHALL have err_bits  out  2: bit0 sticky IF misaligned, bit1 sticky LS misaligned.

Function
REQ-010 SHALL grant at most one requester per cycle; grant and memory drive are combinational from the current requests and registered state.
REQ-011 SHALL use fixed priority LS over IF when both request, except when starve_cnt == STARVE_LIMIT, in which case IF wins.
REQ-012 SHALL keep starve_cnt (2 bits min, saturating at STARVE_LIMIT): increment when if_req=1 and if_gnt=0; clear on any if_gnt; hold when if_req=0.
REQ-013 On a grant with aligned address (addr[1:0]==0), SHALL drive mem_en=1, mem_addr=granted addr, mem_we=ls_we (LS) or 0 (IF), mem_wdata=ls_wdata (LS) or 0 (IF).
REQ-014 With no grant, SHALL drive mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-015 SHALL treat memory read latency as exactly 1 cycle: a read granted in cycle N returns mem_rdata in cycle N+1.
REQ-016 SHALL register a 2-bit owner {NONE, IF, LS} for the read in flight; a write does not set owner.
REQ-017 In cycle N+1, SHALL assert exactly one of if_rvalid/ls_rvalid per owner for one cycle, with the matching rdata = mem_rdata; the non-owner rdata SHALL be 0.
REQ-018 SHALL allow back-to-back grants every cycle (full throughput); a new grant in N+1 is independent of the response being returned in N+1.
REQ-019 SHALL complete a store on ls_gnt alone; ls_rvalid SHALL NOT be asserted for writes.
REQ-020 For a misaligned granted request, SHALL assert gnt, keep mem_en=0, set owner, return rvalid in N+1 with rdata=0, and set the matching err_bits bit.
REQ-021 err_bits SHALL be sticky until rst.
REQ-022 Requesters SHALL hold req/addr/data stable until gnt; the arbiter SHALL NOT depend on deassertion before grant.
REQ-023 Simultaneous requests with the IF forced-priority condition SHALL grant IF and leave LS pending; ls starvation SHALL NOT be tracked.
REQ-024 Implementation SHALL be 120-400 lines of RTL and synthesisable with no latches.

Reset
REQ-025 While rst=1 at a rising clk edge, SHALL set starve_cnt=0, owner=NONE and err_bits=0.
REQ-026 While rst=1, SHALL force all gnt, rvalid and mem_en/mem_we to 0 and all rdata to 0.
REQ-027 An in-flight read during reset SHALL be dropped: no rvalid in the cycle after reset deasserts.
REQ-028 The first grant SHALL be possible in the first cycle with rst=0.

Verification
REQ-029 IF only, if_addr=0x10 for 1 cycle, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1 and mem_addr=0x10 in cycle N; if_rvalid=1, if_rdata=0xDEADBEEF in N+1.
REQ-030 Both requesting, ls_we=1, ls_addr=0x40, ls_wdata=0x5 -> ls_gnt=1, mem_we=1, mem_wdata=0x5, if_gnt=0; no ls_rvalid in N+1.
REQ-031 LS load held continuously and IF held continuously, STARVE_LIMIT=3 -> grants LS,LS,LS,IF,LS,LS,LS,IF...
REQ-032 ls_addr=0x42 load -> ls_gnt=1, mem_en=0; ls_rvalid=1, ls_rdata=0 and err_bits=2'b10 in N+1; err_bits stays 2'b10 until rst.
REQ-033 IF read granted in cycle N, rst=1 in N+1 -> if_rvalid=0 in N+1 and N+2, err_bits=0 and starve_cnt=0.
